mem_access_ctrl: RTL
====================

Name: mem_access_ctrl

Overview:
Initiator side of the byte-addressed data memory interface for the multicycle RISC-V core. It accepts one load or store request at a time from the datapath and drives the memory's address, writeData, memRead and memWrite strobes, which are word-wide. It performs byte and halfword lane extraction with sign or zero extension on loads. Because the memory always writes all 4 bytes, sub-word stores are done as read-modify-write.

Parameters:
MEM_BYTES, 256, size of the addressed memory in bytes; any access whose last byte is at or above MEM_BYTES is an error.
ADDR_W, 32, width of request and memory addresses.

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
req_valid  in  1  request present
req_ready  out  1  block can accept; high only in IDLE
req_write  in  1  1 = store, 0 = load
req_funct3  in  3  RISC-V funct3; loads 000 lb, 001 lh, 010 lw, 100 lbu, 101 lhu; stores 000 sb, 001 sh, 010 sw
req_addr  in  ADDR_W  byte address
req_wdata  in  32  store data, right-aligned
resp_valid  out  1  one-cycle completion pulse
resp_rdata  out  32  extended load data; holds until the next response
resp_err  out  1  qualified by resp_valid
mem_address  out  ADDR_W  word-aligned address to memory
mem_writeData  out  32  full word to write
mem_memRead  out  1  read strobe
mem_memWrite  out  1  write strobe, sampled at the memory's clock edge
mem_memData  in  32  combinational read data from memory

Behaviour:
- Reset (async, active-low):
  - state = IDLE.
  - resp_valid = 0, resp_rdata = 0, resp_err = 0.
  - mem_memRead = 0, mem_memWrite = 0, mem_address = 0, mem_writeData = 0.
  - req_ready = 1 once reset is released.
- All memory-side outputs are Moore outputs decoded from state and registered request fields.
- States: IDLE, READ, WRITE, RESP.
- IDLE:
  - Accept when req_valid && req_ready; latch addr, wdata, funct3 and write.
  - Error check at accept. An error is any of:
    - illegal funct3 (load 011/11x; store anything other than 000/001/010);
    - misaligned access (h: addr[0] != 0; w: addr[1:0] != 0);
    - addr + size > MEM_BYTES.
  - Error -> RESP with err = 1; no strobe is ever asserted.
  - Load, or store with funct3 000/001 -> READ.
  - sw -> WRITE.
- READ:
  - mem_memRead = 1, mem_address = addr & ~3.
  - Capture mem_memData into rbuf at the edge leaving the state.
  - Load -> RESP. Sub-word store -> WRITE.
- WRITE:
  - mem_memWrite = 1, mem_address = addr & ~3.
  - mem_writeData = wdata for sw.
  - For sub-word stores, mem_writeData = rbuf with lane addr[1:0] (byte) or addr[1] (half) replaced by wdata[7:0] or wdata[15:0].
  - -> RESP.
- RESP:
  - resp_valid = 1 for exactly one cycle; req_ready = 0.
  - resp_rdata = selected lane, sign-extended (lb/lh) or zero-extended (lbu/lhu), or the full word (lw).
  - resp_rdata = 0 on stores and on errors.
  - -> IDLE.
- Latency from the accept edge to the resp_valid cycle:
  - error: 1 cycle;
  - load: 2 cycles;
  - sw: 2 cycles;
  - sb/sh: 3 cycles.
- mem_memRead and mem_memWrite are never high in the same cycle.
- At most one strobe cycle per phase.
- req_valid held high during busy states is ignored; the next request is accepted in the first IDLE cycle after RESP.
- Reset mid-operation aborts the transaction:
  - strobes fall immediately;
  - a store whose WRITE edge has not occurred leaves memory unchanged;
  - no resp_valid is produced for the aborted request.
- Address arithmetic uses ADDR_W bits. The range check uses ADDR_W+1 bits so that a wrapping address produces an error.

Decomposition:
- Shared package:
  - state enum (IDLE/READ/WRITE/RESP);
  - funct3 constants (F3_B, F3_H, F3_W, F3_BU, F3_HU);
  - MEM_BYTES default.
- One combinational sub-module, mem_lane_align:
  - inputs: word, addr[1:0], funct3, wdata;
  - outputs: extended load data, merged store word, misalign flag.
- The FSM stays in mem_access_ctrl.

Test Plan:
1. Bench memory word 0x8C = 0x8000_0052; lw 0x8C -> one memRead cycle at mem_address 0x8C; resp_valid 2 cycles after accept; resp_rdata 0x80000052; err 0.
2. lb 0x8F -> 0xFFFFFF80; lbu 0x8F -> 0x00000080; lh 0x8E -> 0xFFFF8000; lhu 0x8C -> 0x00000052.
3. sb wdata 0x123456AB to 0x8D, word 0x80000052 -> memRead one cycle, then memWrite one cycle with writeData 0x8000AB52 at 0x8C; resp_valid at 3 cycles; sw 0x11223344 to 0x90 -> no memRead, writeData 0x11223344.
4. lw 0x8E, sh 0x8D, lw 0x100, lb 0xFF with funct3 011 -> resp_err = 1 one cycle after accept; memRead and memWrite stay 0 throughout.
5. reset driven low during READ of sh 0x8C -> strobes 0 within the same cycle, no resp_valid, memory word unchanged, req_ready = 1 after release.
6. req_valid held high with two queued loads -> req_ready low for READ and RESP, second accept in the IDLE cycle after the first resp_valid; response pulses separated by at least 1 cycle.

Source files
------------

// File: rtl/mem_access_ctrl_pkg.sv
// Shared types and constants for the data-memory access controller.
package mem_access_ctrl_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StRead,
    StWrite,
    StResp
  } state_e;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam int unsigned MEM_BYTES_DEFAULT = 256;

  // Access size in bytes from funct3[1:0]; the 2'b11 encoding is illegal and flagged elsewhere.
  function automatic logic [2:0] access_size(input logic [2:0] funct3);
    logic [2:0] size;
    case (funct3[1:0])
      2'b00:   size = 3'd1;
      2'b01:   size = 3'd2;
      default: size = 3'd4;
    endcase
    return size;
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Byte/halfword lane handling: load extraction with extension, store merge, alignment check.
module mem_lane_align
  import mem_access_ctrl_pkg::*;
(
  input  logic [31:0] i_word,
  input  logic [1:0]  i_addr,
  input  logic [2:0]  i_funct3,
  input  logic [31:0] i_wdata,
  output logic [31:0] o_load_data,
  output logic [31:0] o_store_word,
  output logic        o_misalign
);

  logic [31:0] w_shifted;
  logic [7:0]  w_byte;
  logic [15:0] w_half;

  // Select the addressed lane and extend it for loads.
  always_comb begin
    w_shifted   = i_word >> {i_addr, 3'b000};
    w_byte      = w_shifted[7:0];
    w_half      = i_addr[1] ? i_word[31:16] : i_word[15:0];
    o_load_data = i_word;
    case (i_funct3)
      F3_B:    o_load_data = {{24{w_byte[7]}}, w_byte};
      F3_H:    o_load_data = {{16{w_half[15]}}, w_half};
      F3_BU:   o_load_data = {24'b0, w_byte};
      F3_HU:   o_load_data = {16'b0, w_half};
      default: o_load_data = i_word;
    endcase
  end

  // Merge sub-word store data into the previously read word; full-word stores pass through.
  always_comb begin
    o_store_word = i_word;
    case (i_funct3)
      F3_B:    o_store_word[{i_addr, 3'b000} +: 8]        = i_wdata[7:0];
      F3_H:    o_store_word[{i_addr[1], 4'b0000} +: 16]   = i_wdata[15:0];
      default: o_store_word = i_wdata;
    endcase
  end

  // Halfwords need an even address, words a multiple of four.
  always_comb begin
    o_misalign = 1'b0;
    case (i_funct3[1:0])
      2'b01:   o_misalign = i_addr[0];
      2'b10:   o_misalign = |i_addr;
      default: o_misalign = 1'b0;
    endcase
  end

endmodule

// File: rtl/mem_access_ctrl.sv
// Single-outstanding load/store initiator for a word-wide data memory; sub-word stores use RMW.
module mem_access_ctrl
  import mem_access_ctrl_pkg::*;
#(
  parameter int unsigned MEM_BYTES = MEM_BYTES_DEFAULT,
  parameter int unsigned ADDR_W    = 32
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_req_valid,
  output logic              o_req_ready,
  input  logic              i_req_write,
  input  logic [2:0]        i_req_funct3,
  input  logic [ADDR_W-1:0] i_req_addr,
  input  logic [31:0]       i_req_wdata,
  output logic              o_resp_valid,
  output logic [31:0]       o_resp_rdata,
  output logic              o_resp_err,
  output logic [ADDR_W-1:0] o_mem_address,
  output logic [31:0]       o_mem_writeData,
  output logic              o_mem_memRead,
  output logic              o_mem_memWrite,
  input  logic [31:0]       i_mem_memData
);

  state_e            r_state;
  state_e            w_state_d;
  logic              w_accept;
  logic [ADDR_W-1:0] r_addr;
  logic [31:0]       r_wdata;
  logic [2:0]        r_funct3;
  logic              r_write;
  logic              r_err;
  logic [31:0]       r_rbuf;
  logic [31:0]       r_rdata;

  logic [31:0]       w_la_word;
  logic [1:0]        w_la_addr;
  logic [2:0]        w_la_funct3;
  logic [31:0]       w_load_data;
  logic [31:0]       w_store_word;
  logic              w_misalign;
  logic              w_f3_ok;
  logic [ADDR_W:0]   w_end;
  logic              w_range_err;
  logic              w_req_err;

  // The aligner serves the incoming request in IDLE and the latched request afterwards.
  always_comb begin
    w_la_word   = (r_state == StRead) ? i_mem_memData : r_rbuf;
    w_la_addr   = (r_state == StIdle) ? i_req_addr[1:0] : r_addr[1:0];
    w_la_funct3 = (r_state == StIdle) ? i_req_funct3 : r_funct3;
  end

  mem_lane_align u_lane_align (
    .i_word       (w_la_word),
    .i_addr       (w_la_addr),
    .i_funct3     (w_la_funct3),
    .i_wdata      (r_wdata),
    .o_load_data  (w_load_data),
    .o_store_word (w_store_word),
    .o_misalign   (w_misalign)
  );

  // Request error check; the extra top bit makes a wrapping address fail the range test.
  always_comb begin
    if (i_req_write) begin
      w_f3_ok = i_req_funct3 inside {F3_B, F3_H, F3_W};
    end else begin
      w_f3_ok = i_req_funct3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU};
    end
    w_end       = {1'b0, i_req_addr} + {{(ADDR_W - 2){1'b0}}, access_size(i_req_funct3)};
    w_range_err = w_end > (ADDR_W + 1)'(MEM_BYTES);
    w_req_err   = !w_f3_ok || w_misalign || w_range_err;
  end

  // Next-state logic.
  always_comb begin
    w_state_d = r_state;
    w_accept  = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (i_req_valid) begin
          w_accept = 1'b1;
          if (w_req_err) begin
            w_state_d = StResp;
          end else if (i_req_write && (i_req_funct3 == F3_W)) begin
            w_state_d = StWrite;
          end else begin
            w_state_d = StRead;
          end
        end
      end
      StRead:  w_state_d = r_write ? StWrite : StResp;
      StWrite: w_state_d = StResp;
      StResp:  w_state_d = StIdle;
      default: w_state_d = StIdle;
    endcase
  end

  // Moore outputs decoded from state and latched request fields.
  always_comb begin
    o_req_ready     = (r_state == StIdle);
    o_resp_valid    = (r_state == StResp);
    o_resp_err      = (r_state == StResp) && r_err;
    o_resp_rdata    = r_rdata;
    o_mem_memRead   = (r_state == StRead);
    o_mem_memWrite  = (r_state == StWrite);
    o_mem_address   = '0;
    o_mem_writeData = '0;
    if ((r_state == StRead) || (r_state == StWrite)) begin
      o_mem_address = {r_addr[ADDR_W-1:2], 2'b00};
    end
    if (r_state == StWrite) begin
      o_mem_writeData = w_store_word;
    end
  end

  // State register.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_d;
    end
  end

  // Latch request fields and the error verdict at accept.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_addr   <= '0;
      r_wdata  <= '0;
      r_funct3 <= '0;
      r_write  <= 1'b0;
      r_err    <= 1'b0;
    end else if (w_accept) begin
      r_addr   <= i_req_addr;
      r_wdata  <= i_req_wdata;
      r_funct3 <= i_req_funct3;
      r_write  <= i_req_write;
      r_err    <= w_req_err;
    end
  end

  // Capture the read word on leaving READ; needed for the RMW merge.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_rbuf <= '0;
    end else if (r_state == StRead) begin
      r_rbuf <= i_mem_memData;
    end
  end

  // Response data is loaded on entry to RESP and held until the next response.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_rdata <= '0;
    end else if ((r_state == StRead) && !r_write) begin
      r_rdata <= w_load_data;
    end else if ((r_state == StWrite) || (w_accept && w_req_err)) begin
      r_rdata <= '0;
    end
  end

endmodule
